// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// Bus-facing sequencer for the 16-bit timer core. It holds the CPU-visible
// registers (CTRL, RELOAD, COUNT, STATUS), drives the core strobes, applies a
// programmable prescaler to the core's count-enable, and turns the core's
// sticky interrupt into a write-1-to-clear pending flag with a maskable irq.
//
// Ports
//   clk            system clock, everything on the rising edge
//   rst            synchronous, active-high reset
//   bus_req        access request, held until bus_ack
//   bus_we         1 = write, 0 = read
//   bus_addr       0 CTRL, 1 RELOAD, 2 COUNT (read-only), 3 STATUS
//   bus_wdata      write data
//   bus_rdata      read data, valid while bus_ack is high
//   bus_ack        one-cycle completion pulse
//   irq            pending & ie
//   tmr_cs         core chip select, high in every non-reset cycle
//   tmr_wr         core load strobe (one cycle on enable)
//   tmr_start      core count-enable, one pulse per prescaler period
//   tmr_rd         core snapshot strobe for COUNT reads
//   tmr_datain     reload value presented to the core
//   tmr_clearflag  clears the core's sticky interrupt
//   tmr_intrup     core sticky interrupt
//   tmr_dataout    core count snapshot
//
// CTRL layout: bit0 en, bit1 autoreload, bit2 ie, bits[4 +: prewid] presc.
// timerwid must be at least 4 + prewid so the prescaler field fits in CTRL.
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int timerwid = 16,
    parameter int prewid   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus_req,
    input  logic                bus_we,
    input  logic [1:0]          bus_addr,
    input  logic [timerwid-1:0] bus_wdata,
    output logic [timerwid-1:0] bus_rdata,
    output logic                bus_ack,
    output logic                irq,
    output logic                tmr_cs,
    output logic                tmr_wr,
    output logic                tmr_start,
    output logic                tmr_rd,
    output logic [timerwid-1:0] tmr_datain,
    output logic                tmr_clearflag,
    input  logic                tmr_intrup,
    input  logic [timerwid-1:0] tmr_dataout
);

    typedef enum logic [1:0] {A_CTRL, A_RELOAD, A_COUNT, A_STATUS} addr_t;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    typedef enum logic [1:0] {B_IDLE, B_CNT1, B_CNT2, B_ACK} bus_state_t;

    state_t              state;
    bus_state_t          bus_state;

    logic                ctrl_en;
    logic                ctrl_ar;
    logic                ctrl_ie;
    logic [prewid-1:0]   ctrl_presc;
    logic [timerwid-1:0] reload;
    logic                pending;
    logic [prewid-1:0]   presc_cnt;
    logic                intrup_q;

    // Register-side decode. A request is only taken while the bus FSM is idle,
    // so a write lands on exactly one edge: the accepting one.
    logic accept;
    logic wr_ctrl;
    logic wr_reload;
    logic wr_status_clr;
    logic expiry;

    assign accept        = bus_req && (bus_state == B_IDLE);
    assign wr_ctrl       = accept && bus_we && (addr_t'(bus_addr) == A_CTRL);
    assign wr_reload     = accept && bus_we && (addr_t'(bus_addr) == A_RELOAD);
    assign wr_status_clr = accept && bus_we && (addr_t'(bus_addr) == A_STATUS) && bus_wdata[0];

    // Rising edge of the core's sticky flag; the flag is cleared a cycle later
    // via tmr_clearflag, so each expiry is seen once.
    assign expiry = tmr_intrup && !intrup_q;

    assign tmr_datain = reload;
    assign irq        = pending && ctrl_ie;

    // Write data bits with no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[timerwid-1:4+prewid], bus_wdata[3]};

    // Prescaler period is presc+1 cycles; the count wraps after matching presc.
    logic [prewid-1:0] presc_next;
    assign presc_next = (presc_cnt == ctrl_presc) ? '0 : presc_cnt + prewid'(1);

    // Read mux for the single-cycle registers.
    logic [timerwid-1:0] reg_rdata;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        reg_rdata = '0;
        case (addr_t'(bus_addr))
            A_CTRL: begin
                reg_rdata[0]           = ctrl_en;
                reg_rdata[1]           = ctrl_ar;
                reg_rdata[2]           = ctrl_ie;
                reg_rdata[4 +: prewid] = ctrl_presc;
            end
            A_RELOAD: reg_rdata    = reload;
            A_STATUS: reg_rdata[0] = pending;
            default:  reg_rdata    = '0;
        endcase
    end

    // Main sequencer: IDLE -> LOAD -> RUN, plus the registers it owns.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= IDLE;
            ctrl_en       <= 1'b0;
            ctrl_ar       <= 1'b0;
            ctrl_ie       <= 1'b0;
            ctrl_presc    <= '0;
            reload        <= '0;
            pending       <= 1'b0;
            presc_cnt     <= '0;
            intrup_q      <= 1'b0;
            tmr_cs        <= 1'b0;
            tmr_wr        <= 1'b0;
            tmr_start     <= 1'b0;
            tmr_clearflag <= 1'b0;
        end else begin
            tmr_cs        <= 1'b1;
            tmr_wr        <= 1'b0;
            tmr_start     <= 1'b0;
            intrup_q      <= tmr_intrup;
            tmr_clearflag <= expiry;

            // Set beats clear when both land on the same edge.
            if (expiry)
                pending <= 1'b1;
            else if (wr_status_clr)
                pending <= 1'b0;

            if (wr_reload)
                reload <= bus_wdata;

            if (wr_ctrl) begin
                ctrl_en    <= bus_wdata[0];
                ctrl_ar    <= bus_wdata[1];
                ctrl_ie    <= bus_wdata[2];
                ctrl_presc <= bus_wdata[4 +: prewid];
            end

            // tmr_start is kept equal to (presc_cnt == ctrl_presc) while in RUN,
            // so it is computed from the values the counter is moving to.
            case (state)
                IDLE: begin
                    if (wr_ctrl && bus_wdata[0]) begin
                        state  <= LOAD;
                        tmr_wr <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    presc_cnt <= '0;
                    tmr_start <= (ctrl_presc == '0);
                end
                RUN: begin
                    if (wr_ctrl) begin
                        if (!bus_wdata[0]) begin
                            state <= IDLE;
                        end else begin
                            // Re-enable while running only restarts the prescaler.
                            presc_cnt <= '0;
                            tmr_start <= (bus_wdata[4 +: prewid] == '0);
                        end
                    end else if (expiry && !ctrl_ar) begin
                        state   <= IDLE;
                        ctrl_en <= 1'b0;
                    end else begin
                        presc_cnt <= presc_next;
                        tmr_start <= (presc_next == ctrl_presc);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus handshake. COUNT reads go through the core: strobe rd, give the
    // core a cycle to update dataout, then return it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state <= B_IDLE;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            tmr_rd    <= 1'b0;
        end else begin
            bus_ack <= 1'b0;
            tmr_rd  <= 1'b0;
            case (bus_state)
                B_IDLE: begin
                    if (bus_req) begin
                        if (!bus_we && (addr_t'(bus_addr) == A_COUNT)) begin
                            bus_state <= B_CNT1;
                            tmr_rd    <= 1'b1;
                        end else begin
                            bus_state <= B_ACK;
                            bus_ack   <= 1'b1;
                            if (!bus_we)
                                bus_rdata <= reg_rdata;
                        end
                    end
                end
                B_CNT1: bus_state <= B_CNT2;
                B_CNT2: begin
                    bus_state <= B_ACK;
                    bus_ack   <= 1'b1;
                    bus_rdata <= tmr_dataout;
                end
                B_ACK:   bus_state <= B_IDLE;
                default: bus_state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//
// Drives timer_ctrl against a small behavioural timer core and compares every
// output, every cycle, with a reference model built from the register/timing
// rules (prescaler pulses from tick arithmetic, bus latency from a countdown).
// Directed sections pin the model with hand-computed values; a random section
// then mixes register traffic, enables and resets.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        irq;
    logic        tmr_cs, tmr_wr, tmr_start, tmr_rd;
    logic [15:0] tmr_datain;
    logic        tmr_clearflag;
    logic        tmr_intrup;
    logic [15:0] tmr_dataout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_ctrl #(.timerwid(16), .prewid(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .irq           (irq),
        .tmr_cs        (tmr_cs),
        .tmr_wr        (tmr_wr),
        .tmr_start     (tmr_start),
        .tmr_rd        (tmr_rd),
        .tmr_datain    (tmr_datain),
        .tmr_clearflag (tmr_clearflag),
        .tmr_intrup    (tmr_intrup),
        .tmr_dataout   (tmr_dataout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural timer core ----------------
    // Counts up on start, reloads from datain and raises the sticky flag when
    // it rolls over 16'hFFFF. force_set lets a test raise the flag directly.
    logic        force_set;
    logic [15:0] core_cnt;

    always @(posedge clk) begin
        if (rst) begin
            core_cnt    <= '0;
            tmr_intrup  <= 1'b0;
            tmr_dataout <= '0;
        end else begin
            if (tmr_wr)
                core_cnt <= tmr_datain;
            else if (tmr_start)
                core_cnt <= (core_cnt == 16'hFFFF) ? tmr_datain : core_cnt + 16'd1;
            if ((tmr_start && !tmr_wr && core_cnt == 16'hFFFF) || force_set)
                tmr_intrup <= 1'b1;
            else if (tmr_clearflag)
                tmr_intrup <= 1'b0;
            if (tmr_rd)
                tmr_dataout <= core_cnt;
        end
    end

    // ---------------- reference model ----------------
    logic        m_valid = 1'b0;
    logic        m_en, m_ar, m_ie, m_pending, m_loading, m_running, m_intr_q;
    logic [3:0]  m_presc;
    logic [15:0] m_reload;
    int          m_ticks;     // cycles since RUN entry / prescaler restart
    int          m_bus_left;  // cycles left in the current access, ack cycle = 1

    logic        exp_cs, exp_wr, exp_start, exp_rd, exp_clear, exp_irq, exp_ack;
    logic [15:0] exp_rdata;

    logic m_accept, m_cnt_rd, m_wr_ctrl, m_wr_reload, m_clr, m_edge;
    assign m_accept    = bus_req && (m_bus_left == 0);
    assign m_cnt_rd    = m_accept && !bus_we && (bus_addr == 2'd2);
    assign m_wr_ctrl   = m_accept && bus_we && (bus_addr == 2'd0);
    assign m_wr_reload = m_accept && bus_we && (bus_addr == 2'd1);
    assign m_clr       = m_accept && bus_we && (bus_addr == 2'd3) && bus_wdata[0];
    assign m_edge      = tmr_intrup && !m_intr_q;

    logic [15:0] m_reg_read;
    always_comb begin
        m_reg_read = '0;
        case (bus_addr)
            2'd0:    m_reg_read = {8'h00, m_presc, 1'b0, m_ie, m_ar, m_en};
            2'd1:    m_reg_read = m_reload;
            2'd3:    m_reg_read = {15'h0000, m_pending};
            default: m_reg_read = '0;
        endcase
    end

    logic       n_loading, n_running, n_en, n_pending, n_ie;
    logic [3:0] n_presc;
    int         n_ticks, n_bus_left;
    always_comb begin
        n_loading  = 1'b0;
        n_running  = m_running;
        n_ticks    = m_ticks + 1;
        n_en       = m_wr_ctrl ? bus_wdata[0] : m_en;
        n_ie       = m_wr_ctrl ? bus_wdata[2] : m_ie;
        n_presc    = m_wr_ctrl ? bus_wdata[7:4] : m_presc;
        n_pending  = m_edge || (m_pending && !m_clr);
        n_bus_left = m_accept ? (m_cnt_rd ? 3 : 1) : ((m_bus_left > 0) ? m_bus_left - 1 : 0);
        if (m_loading) begin
            n_running = 1'b1;
            n_ticks   = 0;
        end else if (m_running) begin
            if (m_wr_ctrl) begin
                n_running = bus_wdata[0];
                n_ticks   = 0;
            end else if (m_edge && !m_ar) begin
                n_running = 1'b0;
                n_en      = 1'b0;
            end
        end else if (m_wr_ctrl && bus_wdata[0]) begin
            n_loading = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b1;
            m_en       <= 1'b0;
            m_ar       <= 1'b0;
            m_ie       <= 1'b0;
            m_presc    <= '0;
            m_reload   <= '0;
            m_pending  <= 1'b0;
            m_loading  <= 1'b0;
            m_running  <= 1'b0;
            m_intr_q   <= 1'b0;
            m_ticks    <= 0;
            m_bus_left <= 0;
            exp_cs     <= 1'b0;
            exp_wr     <= 1'b0;
            exp_start  <= 1'b0;
            exp_rd     <= 1'b0;
            exp_clear  <= 1'b0;
            exp_irq    <= 1'b0;
            exp_ack    <= 1'b0;
            exp_rdata  <= '0;
        end else begin
            m_en       <= n_en;
            m_ar       <= m_wr_ctrl ? bus_wdata[1] : m_ar;
            m_ie       <= n_ie;
            m_presc    <= n_presc;
            m_reload   <= m_wr_reload ? bus_wdata : m_reload;
            m_pending  <= n_pending;
            m_loading  <= n_loading;
            m_running  <= n_running;
            m_intr_q   <= tmr_intrup;
            m_ticks    <= n_ticks;
            m_bus_left <= n_bus_left;
            exp_cs     <= 1'b1;
            exp_wr     <= n_loading;
            exp_start  <= n_running && ((n_ticks % (int'(n_presc) + 1)) == int'(n_presc));
            exp_rd     <= (n_bus_left == 3);
            exp_clear  <= m_edge;
            exp_irq    <= n_pending && n_ie;
            exp_ack    <= (n_bus_left == 1);
            if (m_accept && !bus_we && !m_cnt_rd)
                exp_rdata <= m_reg_read;
            else if (m_bus_left == 2)
                exp_rdata <= tmr_dataout;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("tmr_cs",        32'(tmr_cs),        32'(exp_cs));
            check("tmr_wr",        32'(tmr_wr),        32'(exp_wr));
            check("tmr_start",     32'(tmr_start),     32'(exp_start));
            check("tmr_rd",        32'(tmr_rd),        32'(exp_rd));
            check("tmr_clearflag", 32'(tmr_clearflag), 32'(exp_clear));
            check("irq",           32'(irq),           32'(exp_irq));
            check("bus_ack",       32'(bus_ack),       32'(exp_ack));
            check("tmr_datain",    32'(tmr_datain),    32'(m_reload));
            if (exp_ack)
                check("bus_rdata", 32'(bus_rdata), 32'(exp_rdata));
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_wait(output logic [15:0] rd, output int lat);
        bit done = 1'b0;
        lat = 0;
        rd  = '0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_ack) begin
                rd   = bus_rdata;
                done = 1'b1;
            end
        end
        if (!done)
            check("bus_ack_timeout", 32'(bus_ack), 32'd1);
        @(negedge clk);
        bus_req = 1'b0;
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        bus_wait(rd, lat);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] wd);
        logic [15:0] rd;
        int          lat;
        bus_xfer(1'b1, addr, wd, rd, lat);
        check("write_latency", 32'(lat), 32'd1);
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [15:0] rd, output int lat);
        bus_xfer(1'b0, addr, 16'h0000, rd, lat);
    endtask

    // Counts start pulses per expiry round until `want` rising edges of the
    // core flag have been seen or the budget runs out.
    task automatic watch_expiry(input int want, input int budget,
                                output int r0, output int r1, output int seen, output int cf);
        int   starts = 0;
        logic prev   = tmr_intrup;
        r0 = -1; r1 = -1; seen = 0; cf = 0;
        for (int c = 0; c < budget && seen < want; c++) begin
            @(negedge clk);
            if (tmr_intrup && !prev) begin
                if (seen == 0) r0 = starts; else r1 = starts;
                seen++;
                starts = 0;
            end
            if (tmr_start) starts++;
            if (tmr_clearflag) cf++;
            prev = tmr_intrup;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rd;
        int          lat, r0, r1, seen, cf, cnt, first, prev_at;

        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0;
        bus_wdata = '0; force_set = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of all registers.
        rd_reg(2'd0, rd, lat); check("reset_ctrl", 32'(rd), 32'h0);
        check("ctrl_read_latency", 32'(lat), 32'd1);
        rd_reg(2'd1, rd, lat); check("reset_reload", 32'(rd), 32'h0);
        rd_reg(2'd2, rd, lat); check("reset_count", 32'(rd), 32'h0);
        check("count_read_latency", 32'(lat), 32'd3);
        rd_reg(2'd3, rd, lat); check("reset_status", 32'(rd), 32'h0);
        check("reset_irq", 32'(irq), 32'd0);

        // Auto-reload, presc 0: 16 starts per expiry from FFF0.
        wr(2'd1, 16'hFFF0);
        wr(2'd0, 16'h0007);
        check("load_wr", 32'(tmr_wr), 32'd1);
        check("load_datain", 32'(tmr_datain), 32'hFFF0);
        watch_expiry(2, 200, r0, r1, seen, cf);
        check("ar_expiries_seen", 32'(seen), 32'd2);
        check("ar_first_round", 32'(r0), 32'd16);
        check("ar_second_round", 32'(r1), 32'd16);
        check("ar_clearflag_cycles", 32'(cf), 32'd1);
        check("ar_irq", 32'(irq), 32'd1);
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'h0001);

        // One-shot from FFFE: one expiry after two starts, then idle.
        wr(2'd1, 16'hFFFE);
        wr(2'd0, 16'h0005);
        watch_expiry(1, 50, r0, r1, seen, cf);
        check("os_expiry_seen", 32'(seen), 32'd1);
        check("os_round", 32'(r0), 32'd2);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tmr_start) cnt++;
        end
        check("os_starts_after_expiry", 32'(cnt), 32'd0);
        rd_reg(2'd0, rd, lat); check("os_ctrl_en_cleared", 32'(rd), 32'h0004);
        rd_reg(2'd3, rd, lat); check("os_status", 32'(rd), 32'h1);
        wr(2'd3, 16'h0001);
        wr(2'd0, 16'h0000);

        // presc 3: start every 4th cycle, first one 4 cycles into RUN.
        wr(2'd1, 16'h1000);
        wr(2'd0, 16'h0031);
        cnt = 0; first = -1; prev_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (tmr_start) begin
                if (first < 0) first = c;
                else check("presc3_gap", 32'(c - prev_at), 32'd4);
                prev_at = c;
                cnt++;
            end
        end
        check("presc3_first", 32'(first), 32'd4);
        check("presc3_pulses", 32'(cnt), 32'd5);
        rd_reg(2'd2, rd, lat);
        check("presc3_count_latency", 32'(lat), 32'd3);
        check("presc3_count_hi", 32'(rd[15:8]), 32'h10);

        // Expiry on the same edge as a STATUS clear: set wins.
        wr(2'd0, 16'h0004);
        @(negedge clk);
        force_set = 1'b1;
        @(negedge clk);
        force_set = 1'b0;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 2'd3; bus_wdata = 16'h0001;
        bus_wait(rd, lat);
        rd_reg(2'd3, rd, lat); check("set_wins_status", 32'(rd), 32'h1);
        check("set_wins_irq", 32'(irq), 32'd1);
        wr(2'd3, 16'h0001);
        check("irq_dropped", 32'(irq), 32'd0);
        rd_reg(2'd3, rd, lat); check("status_cleared", 32'(rd), 32'h0);

        // Reset in the middle of a COUNT read while running.
        wr(2'd1, 16'h0000);
        wr(2'd0, 16'h0003);
        repeat (3) @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd2;
        @(negedge clk);
        check("cnt1_rd", 32'(tmr_rd), 32'd1);
        @(negedge clk);
        rst = 1'b1; bus_req = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_rdata", 32'(bus_rdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cs", 32'(tmr_cs), 32'd0);
        check("rst_wr", 32'(tmr_wr), 32'd0);
        check("rst_start", 32'(tmr_start), 32'd0);
        check("rst_rd", 32'(tmr_rd), 32'd0);
        check("rst_clearflag", 32'(tmr_clearflag), 32'd0);
        check("rst_datain", 32'(tmr_datain), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_ack", 32'(bus_ack), 32'd0);
            check("post_rst_start", 32'(tmr_start), 32'd0);
        end

        // Random traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 250; n++) begin
            int          op;
            logic [15:0] wd;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
            op = $urandom_range(0, 99);
            wd = 16'($urandom);
            if (op < 25) begin
                wd[7:4] = 4'($urandom_range(0, 3));
                wd[0]   = ($urandom_range(0, 9) < 7);
                bus_xfer(1'b1, 2'd0, wd, rd, lat);
            end else if (op < 45) begin
                if ($urandom_range(0, 3) != 0) wd = 16'hFFF0 | 16'($urandom_range(0, 15));
                bus_xfer(1'b1, 2'd1, wd, rd, lat);
            end else if (op < 60) begin
                bus_xfer(1'b1, 2'd3, wd, rd, lat);
            end else if (op < 70) begin
                bus_xfer(1'b1, 2'd2, wd, rd, lat);
            end else begin
                bus_xfer(1'b0, 2'($urandom_range(0, 3)), 16'h0000, rd, lat);
            end
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Bus-facing controller that sequences the 16-bit timer core in the MCU peripheral space. It exposes four registers to the CPU (control, reload, count, status), generates the core's `cs`/`wr`/`start`/`rd`/`datain`/`clearFlag` strobes, and applies a programmable prescaler. It supports one-shot and auto-reload modes. It converts the core's sticky interrupt into a pending flag with write-1-to-clear semantics and a maskable `irq`.

## Interface
- `timerwid`, 16: width of timer core data, reload and count.
- `prewid`, 4: width of prescaler field; tick every (PRESC+1) clocks.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_req`  in  1  access request, held until `bus_ack`.
- `bus_we`  in  1  1 = write, 0 = read; stable while `bus_req`.
- `bus_addr`  in  2  0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS.
- `bus_wdata`  in  timerwid  write data.
- `bus_rdata`  out  timerwid  read data, valid when `bus_ack`=1.
- `bus_ack`  out  1  one-cycle completion pulse.
- `irq`  out  1  `pending & ie`.
- `tmr_cs`, `tmr_wr`, `tmr_start`, `tmr_rd`  out  1 each  timer core strobes.
- `tmr_datain`  out  timerwid  reload value to core.
- `tmr_clearflag`  out  1  clear strobe to core.
- `tmr_intrup`  in  1  core sticky interrupt.
- `tmr_dataout`  in  timerwid  core count snapshot.

## Operation
- CTRL fields: bit0 `en`, bit1 `autoreload`, bit2 `ie`, bits[4+prewid-1:4] `presc`. All other bits read 0.
- RELOAD register drives `tmr_datain` combinationally at all times.
- STATUS: bit0 is `pending`. A write with bit0=1 clears it. A write with bit0=0 has no effect.
- COUNT: read-only. Writes are acked and ignored.
- Main FSM states: IDLE, LOAD, RUN.
  - IDLE: `tmr_start`=0. A CTRL write with `en`=1 → LOAD.
  - LOAD: one cycle with `tmr_wr`=1 and `tmr_start`=0, so the core loads RELOAD. Then → RUN.
  - RUN: a prescaler counter counts 0..presc. `tmr_start`=1 for exactly the one cycle in which the prescaler equals presc; the prescaler then wraps to 0. When presc=0, `tmr_start` is high every cycle.
  - RUN exits: a CTRL write with `en`=0 → IDLE; the count holds in the core. Expiry in one-shot mode → IDLE and hardware clears `en`.
- Expiry is the rising edge of `tmr_intrup`, detected with one registered copy.
  - On expiry: `pending`←1 and `tmr_clearflag` pulses high for exactly 1 cycle, the cycle after detection.
  - In auto-reload mode: stay in RUN. The core has already reloaded from `tmr_datain`.
- `tmr_cs`=1 in every cycle except reset.
- Bus FSM states: B_IDLE, B_CNT1, B_CNT2, B_ACK. It runs independently of the main FSM.
  - Register access (non-COUNT read, or any write): → B_ACK. The write takes effect on the request edge; `bus_ack` pulses the next cycle.
  - COUNT read, B_CNT1: `tmr_rd`=1 for 1 cycle.
  - COUNT read, B_CNT2: wait for the core `dataout` update.
  - COUNT read, B_ACK: `bus_rdata`=`tmr_dataout`, `bus_ack`=1.
  - After B_ACK: return to B_IDLE. A new request is accepted no earlier than the cycle after the ack.
- Writing RELOAD while in RUN updates `tmr_datain` immediately. It does not reload the current count; the new value takes effect at the next wrap.
- A CTRL write with `en`=1 while already in RUN does not re-enter LOAD. It only updates `autoreload`, `ie` and `presc`; the prescaler counter resets to 0.

## Timing
- Reset values:
  - state IDLE and B_IDLE.
  - CTRL=0, RELOAD=0, `pending`=0.
  - `bus_ack`=0, `bus_rdata`=0, `irq`=0.
  - `tmr_cs`/`tmr_wr`/`tmr_start`/`tmr_rd`/`tmr_clearflag`=0, `tmr_datain`=0.
  - Prescaler and edge-detect registers cleared.
- Reset asserted mid-count or mid-read: every output reaches its reset value on the next edge. A pending `bus_ack` is dropped.
- Write latency: `bus_ack` 1 cycle after the accepting edge.
- Read latency: non-COUNT reads 1 cycle; COUNT reads 3 cycles.
- Enable to first `tmr_start`: LOAD occupies the cycle after the CTRL write edge. The first start pulse comes presc+1 cycles after entering RUN.
- Expiry and a STATUS clear in the same cycle: set wins, `pending` stays 1.
- Expiry in the same cycle as a CTRL `en`=0 write: go to IDLE, `pending` still set.
- The prescaler compares against the presc value latched in CTRL, in `prewid`-bit unsigned arithmetic. All counts wrap modulo 2^width.

## Test plan
- Reset, then read all four registers → CTRL=0, RELOAD=0, COUNT=0, STATUS=0; `irq`=0.
- RELOAD=16'hFFF0, CTRL=16'h0007 (en, autoreload, ie, presc=0) → `tmr_wr` 1 cycle with datain FFF0; first expiry after 16 start pulses; `irq`=1; `tmr_clearflag` 1-cycle pulse; second expiry 16 starts later.
- One-shot: RELOAD=16'hFFFE, CTRL=16'h0005 → single expiry after 2 starts; FSM back in IDLE; CTRL reads 16'h0004; `tmr_start` stays 0.
- presc=3 (CTRL=16'h0031) → `tmr_start` high exactly every 4th cycle; COUNT read returns the core count with `bus_ack` 3 cycles after the request.
- Force expiry in the same cycle as a STATUS write of 1 → STATUS reads 1. A later STATUS write of 1 → 0 and `irq` drops the next cycle.
- Assert `rst` during B_CNT2 while in RUN → no `bus_ack`; all outputs at reset values; `tmr_start`=0 the cycle after reset.
